// File: rtl/muldiv_unit_if.sv
// Request/response bundle between operand read, the multiply/divide unit and register write-back.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic        wb_regwrite;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_writedata;

    modport master (
        output start, funct3, op_a, op_b, rd_in, flush,
        input  busy, done, wb_regwrite, wb_writereg, wb_writedata
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, flush,
        output busy, done, wb_regwrite, wb_writereg, wb_writedata
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add / restoring-divide steps on latched magnitudes.
// Done pulses 33 edges after the accepting edge; no backpressure, start is only honoured in IDLE.
module muldiv_unit (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_finish;
    logic        w_iter;

    logic [5:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_m;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_bzero;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_reg;

    logic        w_sgn_a;
    logic        w_sgn_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    always_comb begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin
                w_sgn_a = bus.op_a[31];
                w_sgn_b = bus.op_b[31];
            end
            3'b010:  w_sgn_a = bus.op_a[31];
            default: ;
        endcase
    end

    assign w_mag_a = w_sgn_a ? (32'd0 - bus.op_a) : bus.op_a;
    assign w_mag_b = w_sgn_b ? (32'd0 - bus.op_b) : bus.op_b;

    // Counter runs 0..31 doing one step per edge; the edge after step 31 applies the sign fix-up.
    assign w_iter = (r_state == CALC) && (r_cnt != 6'd32);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 6'd32) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    logic [32:0] w_mul_sum;
    logic [32:0] w_div_sh;
    logic        w_div_ge;
    logic [31:0] w_div_sub;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : 33'd0);
    assign w_div_sh  = {r_hi, r_lo[31]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_m});
    assign w_div_sub = w_div_sh[31:0] - r_m;

    logic [63:0] w_prod_s;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_result;

    // A zero divisor leaves the all-ones quotient unsigned; the remainder then already equals op_a.
    assign w_prod_s = r_neg_q ? (64'd0 - {r_hi, r_lo}) : {r_hi, r_lo};
    assign w_quot   = (r_neg_q && !r_bzero) ? (32'd0 - r_lo) : r_lo;
    assign w_rem    = r_neg_r ? (32'd0 - r_hi) : r_hi;

    always_comb begin
        w_result = 32'd0;
        case (r_funct3)
            3'b000:                 w_result = w_prod_s[31:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_s[63:32];
            3'b100, 3'b101:         w_result = w_quot;
            default:                w_result = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 6'd0;
            r_funct3  <= 3'd0;
            r_rd      <= 5'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_m       <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_bzero   <= 1'b0;
            r_wb_data <= 32'd0;
            r_wb_reg  <= 5'd0;
        end else begin
            if (w_accept) begin
                r_cnt    <= 6'd0;
                r_funct3 <= bus.funct3;
                r_rd     <= bus.rd_in;
                r_hi     <= 32'd0;
                r_lo     <= bus.funct3[2] ? w_mag_a : w_mag_b;
                r_m      <= bus.funct3[2] ? w_mag_b : w_mag_a;
                r_neg_q  <= w_sgn_a ^ w_sgn_b;
                r_neg_r  <= w_sgn_a;
                r_bzero  <= (bus.op_b == 32'd0);
            end else if (w_iter) begin
                r_cnt <= r_cnt + 6'd1;
                if (r_funct3[2]) begin
                    r_hi <= w_div_ge ? w_div_sub : w_div_sh[31:0];
                    r_lo <= {r_lo[30:0], w_div_ge};
                end else begin
                    r_hi <= w_mul_sum[32:1];
                    r_lo <= {w_mul_sum[0], r_lo[31:1]};
                end
            end
            if (w_finish) begin
                r_wb_data <= w_result;
                r_wb_reg  <= r_rd;
            end
        end
    end

    assign bus.busy         = (r_state == CALC);
    assign bus.done         = (r_state == DONE);
    assign bus.wb_regwrite  = (r_state == DONE) && (r_wb_reg != 5'd0);
    assign bus.wb_writereg  = r_wb_reg;
    assign bus.wb_writedata = r_wb_data;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, randomized ops, flush/reset aborts.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          issue;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    bit          mon_en    = 1'b0;
    logic [31:0] last_data = 32'd0;
    logic [4:0]  last_reg  = 5'd0;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } op_t;

    localparam op_t DIR [16] = '{
        '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB},
        '{3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000},
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE},
        '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF},
        '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd4,  32'hFFFFFFFD},
        '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF},
        '{3'd5, 32'd100,      32'd7,        5'd7,  32'd14},
        '{3'd7, 32'd100,      32'd7,        5'd8,  32'd2},
        '{3'd5, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF},
        '{3'd7, 32'd5,        32'd0,        5'd10, 32'd5},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000},
        '{3'd0, 32'd3,        32'd4,        5'd0,  32'd12},
        '{3'd4, 32'd7,        32'd0,        5'd13, 32'hFFFFFFFF},
        '{3'd6, 32'hFFFFFFF9, 32'd0,        5'd14, 32'hFFFFFFF9},
        '{3'd4, 32'hFFFFFFF9, 32'd0,        5'd15, 32'hFFFFFFFF}
    };

    // Reference model: plain 64-bit and C-style signed arithmetic plus the RV32M special cases.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int          ia;
        int          ib;
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        int s;
        s = $urandom_range(0, 9);
        case (s)
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse; between pulses the write-back outputs must hold.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done data=%h reg=%0d at cycle %0d", bus.wb_writedata, bus.wb_writereg, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("wb_writedata", bus.wb_writedata, mon_e.data);
                    chk("wb_writereg", {27'd0, bus.wb_writereg}, {27'd0, mon_e.rd});
                    chk("wb_regwrite", {31'd0, bus.wb_regwrite}, {31'd0, (mon_e.rd != 5'd0)});
                    chk("latency", cyc - mon_e.issue, 32'd33);
                    chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
                    last_data = mon_e.data;
                    last_reg  = mon_e.rd;
                end
            end else begin
                chk("regwrite_idle", {31'd0, bus.wb_regwrite}, 32'd0);
                chk("hold_data", bus.wb_writedata, last_data);
                chk("hold_reg", {27'd0, bus.wb_writereg}, {27'd0, last_reg});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push, input logic [31:0] exp);
        int n;
        n = 0;
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%b done=%b", bus.busy, bus.done);
        end
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        if (push) begin
            exp_t e;
            e.data  = exp;
            e.rd    = rd;
            e.issue = cyc + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done(input bit noise);
        int n;
        n = 0;
        while (!bus.done && n < 60) begin
            if (noise) begin
                bus.start  = 1'($urandom_range(0, 1));
                bus.funct3 = 3'($urandom_range(0, 7));
                bus.op_a   = $urandom;
                bus.rd_in  = 5'($urandom_range(0, 31));
            end
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, bus.done}, 32'd1);
        if (noise) bus.start = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit noise);
        issue(f, a, b, rd, 1'b1, exp);
        wait_done(noise);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rr;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        bus.rd_in  = 5'd0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_regwrite", {31'd0, bus.wb_regwrite}, 32'd0);
        chk("rst_writereg", {27'd0, bus.wb_writereg}, 32'd0);
        chk("rst_writedata", bus.wb_writedata, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_op(DIR[i].f, DIR[i].a, DIR[i].b, DIR[i].rd, DIR[i].exp, bit'(i % 2));
        end

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            rr = 5'($urandom_range(0, 31));
            do_op(rf, ra, rb, rr, ref_model(rf, ra, rb), 1'($urandom_range(0, 1)));
        end

        // Flush ten cycles into an operation, then restart on the very next edge.
        issue(3'd5, 32'd1000, 32'd3, 5'd20, 1'b0, 32'd0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("busy_after_flush", {31'd0, bus.busy}, 32'd0);
        do_op(3'd3, 32'h12345678, 32'h9ABCDEF0, 5'd21, ref_model(3'd3, 32'h12345678, 32'h9ABCDEF0), 1'b0);

        // Flush together with start in IDLE drops the start.
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = 3'd0;
        bus.rd_in  = 5'd22;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_beats_start", {31'd0, bus.busy}, 32'd0);

        // Reset in the middle of CALC.
        issue(3'd0, 32'hDEADBEEF, 32'h0BADF00D, 5'd23, 1'b0, 32'd0);
        repeat (14) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_regwrite", {31'd0, bus.wb_regwrite}, 32'd0);
        chk("midrst_writereg", {27'd0, bus.wb_writereg}, 32'd0);
        chk("midrst_writedata", bus.wb_writedata, 32'd0);
        last_data = 32'd0;
        last_reg  = 5'd0;
        rst       = 1'b0;
        mon_en    = 1'b1;
        @(negedge clk);
        do_op(3'd6, 32'hFFFFFF9C, 32'd7, 5'd24, ref_model(3'd6, 32'hFFFFFF9C, 32'd7), 1'b1);

        repeat (50) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
